// File: rtl/inst_fetcher_if.sv
// Fetch-unit bus bundle: redirect input, instruction memory request/response,
// and the push port into the downstream instruction queue.
interface inst_fetcher_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ireq_valid;
    logic        ireq_ready;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_inst;
    logic        qwready;
    logic        qwvalid;
    logic [63:0] qwdata;
    logic        qkill;

    // Fetcher side
    modport master (
        input  redirect_valid, redirect_pc, ireq_ready, iresp_valid, iresp_inst, qwready,
        output ireq_valid, ireq_addr, qwvalid, qwdata, qkill
    );

    // Environment side (memory, queue, redirect source)
    modport slave (
        output redirect_valid, redirect_pc, ireq_ready, iresp_valid, iresp_inst, qwready,
        input  ireq_valid, ireq_addr, qwvalid, qwdata, qkill
    );
endinterface

// File: rtl/inst_fetcher.sv
// Single-outstanding instruction fetcher: requests one word at pc, waits for the
// response, pushes {pc, inst} downstream, then moves on. Redirects take priority
// over everything and flush the downstream queue via qkill.
module inst_fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst_n,
    inst_fetcher_if.master fif
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StPush = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [63:0] buffer_q, buffer_d;

    logic        redirect;
    logic [31:0] redirect_pc_aligned;

    assign redirect            = fif.redirect_valid;
    assign redirect_pc_aligned = {fif.redirect_pc[31:2], 2'b00};

    // Outputs: a redirect cycle suppresses both request and push.
    always_comb begin
        fif.ireq_valid = (state_q == StReq) && !redirect;
        fif.ireq_addr  = pc_q;
        fif.qwvalid    = (state_q == StPush) && !redirect;
        fif.qwdata     = buffer_q;
        fif.qkill      = redirect;
    end

    // Next-state logic; redirect handling sits first in every state.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        buffer_d  = buffer_q;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                if (redirect) pc_d = redirect_pc_aligned;
            end
            StReq: begin
                if (redirect) begin
                    pc_d = redirect_pc_aligned;
                end else if (fif.ireq_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect) begin
                    pc_d = redirect_pc_aligned;
                    if (fif.iresp_valid) begin
                        // The in-flight response is consumed (and dropped) right now.
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end else begin
                        // Response still in flight; remember to drop it.
                        discard_d = 1'b1;
                    end
                end else if (fif.iresp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = StReq;
                    end else begin
                        buffer_d = {pc_q, fif.iresp_inst};
                        pc_d     = pc_q + 32'd4;
                        state_d  = StPush;
                    end
                end
            end
            StPush: begin
                if (redirect) begin
                    pc_d    = redirect_pc_aligned;
                    state_d = StReq;
                end else if (fif.qwready) begin
                    state_d = StReq;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            buffer_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            buffer_q  <= buffer_d;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// Scoreboard bench for inst_fetcher: a memory responder and stimulus drive the
// bus; a negedge monitor keeps a transaction-level model of the fetch stream and
// compares every push, request address and handshake rule against it.
module tb_inst_fetcher;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;

    inst_fetcher_if fif ();

    inst_fetcher #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fif   (fif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_push = 0;
    int resp_lat = 1;  // 0 selects a random latency per request

    // Scoreboard and transaction-level model state
    logic [63:0] exp_q[$];
    logic [31:0] next_fetch;
    logic [31:0] out_addr;
    logic        outstanding;
    logic        stale;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h0000_0013;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Memory responder: one response per accepted request after a 1..4 cycle latency.
    initial begin
        fif.iresp_valid = 1'b0;
        fif.iresp_inst  = 32'd0;
        forever begin
            logic [31:0] a;
            int lat;
            @(negedge clk);
            if (rst_n && fif.ireq_valid && fif.ireq_ready) begin
                a   = fif.ireq_addr;
                lat = (resp_lat == 0) ? int'($urandom_range(1, 4)) : resp_lat;
                @(posedge clk);
                repeat (lat - 1) @(posedge clk);
                #1;
                fif.iresp_valid = 1'b1;
                fif.iresp_inst  = mem_word(a);
                @(posedge clk);
                #1;
                fif.iresp_valid = 1'b0;
                fif.iresp_inst  = 32'd0;
            end
        end
    end

    // Monitor: model the architectural fetch stream and check the DUT against it.
    initial begin
        logic        hold_q, hold_r;
        logic [63:0] prev_qwdata;
        logic [31:0] prev_addr;
        hold_q = 1'b0;
        hold_r = 1'b0;
        prev_qwdata = '0;
        prev_addr   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                next_fetch  = RST_PC;
                outstanding = 1'b0;
                stale       = 1'b0;
                hold_q      = 1'b0;
                hold_r      = 1'b0;
                continue;
            end
            check("qkill", 64'(fif.qkill), 64'(fif.redirect_valid));
            if (fif.redirect_valid) begin
                check("ireq_during_redirect", 64'(fif.ireq_valid), 64'd0);
                check("push_during_redirect", 64'(fif.qwvalid), 64'd0);
            end
            if (fif.qwvalid) check("ireq_during_push", 64'(fif.ireq_valid), 64'd0);
            if (hold_q && !fif.redirect_valid) begin
                check("qwvalid_held", 64'(fif.qwvalid), 64'd1);
                check("qwdata_held", fif.qwdata, prev_qwdata);
            end
            if (hold_r && !fif.redirect_valid) begin
                check("ireq_valid_held", 64'(fif.ireq_valid), 64'd1);
                check("ireq_addr_held", 64'(fif.ireq_addr), 64'(prev_addr));
            end
            if (fif.ireq_valid && fif.ireq_ready) begin
                check("ireq_addr", 64'(fif.ireq_addr), 64'(next_fetch));
                outstanding = 1'b1;
                stale       = 1'b0;
                out_addr    = next_fetch;
            end
            if (fif.qwvalid && fif.qwready) begin
                n_push++;
                if (exp_q.size() == 0) fail_now("unexpected_push");
                else check("qwdata", fif.qwdata, exp_q.pop_front());
            end
            if (fif.iresp_valid) begin
                if (!fif.redirect_valid && !stale) begin
                    exp_q.push_back({out_addr, mem_word(out_addr)});
                    next_fetch = out_addr + 32'd4;
                end
                outstanding = 1'b0;
                stale       = 1'b0;
            end
            if (fif.redirect_valid) begin
                next_fetch = {fif.redirect_pc[31:2], 2'b00};
                if (outstanding) stale = 1'b1;
                exp_q.delete();
            end
            hold_q      = fif.qwvalid && !fif.qwready;
            hold_r      = fif.ireq_valid && !fif.ireq_ready;
            prev_qwdata = fif.qwdata;
            prev_addr   = fif.ireq_addr;
        end
    end

    task automatic wait_handshake();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fif.ireq_valid && fif.ireq_ready) break;
        end
        if (i == 100) fail_now("timeout_handshake");
        @(posedge clk);
    endtask

    task automatic wait_qwvalid();
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fif.qwvalid) break;
        end
        if (i == 100) fail_now("timeout_qwvalid");
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = pc;
        @(posedge clk);
        #1;
        fif.redirect_valid = 1'b0;
    endtask

    // Stimulus: directed scenarios, then randomized traffic, then drain.
    initial begin
        int i;
        rst_n              = 1'b0;
        fif.redirect_valid = 1'b1;
        fif.redirect_pc    = 32'h40;
        fif.ireq_ready     = 1'b0;
        fif.qwready        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ireq_valid", 64'(fif.ireq_valid), 64'd0);
        check("rst_qwvalid", 64'(fif.qwvalid), 64'd0);
        check("rst_qwdata", fif.qwdata, 64'd0);
        check("rst_ireq_addr", 64'(fif.ireq_addr), 64'(RST_PC));
        check("rst_qkill_hi", 64'(fif.qkill), 64'd1);
        fif.redirect_valid = 1'b0;
        @(negedge clk);
        check("rst_qkill_lo", 64'(fif.qkill), 64'd0);
        @(posedge clk);
        #1;
        fif.ireq_ready = 1'b1;
        fif.qwready    = 1'b1;
        rst_n          = 1'b1;
        repeat (12) @(posedge clk);

        // Downstream back-pressure for 5 cycles in PUSH
        #1 fif.qwready = 1'b0;
        wait_qwvalid();
        repeat (5) @(posedge clk);
        #1 fif.qwready = 1'b1;
        repeat (6) @(posedge clk);

        // Redirect while a slow response is in flight
        resp_lat = 4;
        wait_handshake();
        #1 pulse_redirect(32'h100);
        repeat (12) @(posedge clk);

        // Redirect in the same cycle as the response
        resp_lat = 2;
        wait_handshake();
        @(posedge clk);
        #1 pulse_redirect(32'h200);
        repeat (12) @(posedge clk);

        // Wrap at the top of the address space
        resp_lat = 1;
        #1 pulse_redirect(32'hFFFF_FFFC);
        repeat (12) @(posedge clk);

        // Unaligned redirect that kills a pending push
        #1 fif.qwready = 1'b0;
        wait_qwvalid();
        @(posedge clk);
        #1 fif.qwready = 1'b1;
        pulse_redirect(32'h103);
        repeat (10) @(posedge clk);

        // Reset while holding a push: buffer must be gone after release
        #1 fif.qwready = 1'b0;
        wait_qwvalid();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("midrst_qwvalid", 64'(fif.qwvalid), 64'd0);
        check("midrst_qwdata", fif.qwdata, 64'd0);
        check("midrst_ireq_addr", 64'(fif.ireq_addr), 64'(RST_PC));
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        fif.qwready = 1'b1;
        repeat (8) @(posedge clk);

        // Randomized traffic
        resp_lat = 0;
        n_push   = 0;
        for (i = 0; i < 1500; i++) begin
            #1;
            fif.ireq_ready     = ($urandom_range(0, 3) != 0);
            fif.qwready        = ($urandom_range(0, 9) < 7);
            fif.redirect_valid = ($urandom_range(0, 19) == 0);
            fif.redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
            @(posedge clk);
        end
        #1;
        fif.redirect_valid = 1'b0;
        fif.ireq_ready     = 1'b0;
        fif.qwready        = 1'b1;
        check("random_push_count", 64'(n_push >= 40), 64'd1);

        // Drain: everything the model expects must come out
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !outstanding) break;
        end
        check("drained", 64'(exp_q.size() == 0 && !outstanding), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
